// File: rtl/zybo_pwmext_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper for the
// Zybo PWMext AXI4-Lite register block.
package zybo_pwmext_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_DUTY    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/zybo_pwmext_axil_regs_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the PWMext
// register block (slave).
interface zybo_pwmext_axil_regs_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 4
);
  logic [AddrWidth-1:0]   S_AXI_AWADDR;
  logic [2:0]             S_AXI_AWPROT;
  logic                   S_AXI_AWVALID;
  logic                   S_AXI_AWREADY;
  logic [DataWidth-1:0]   S_AXI_WDATA;
  logic [DataWidth/8-1:0] S_AXI_WSTRB;
  logic                   S_AXI_WVALID;
  logic                   S_AXI_WREADY;
  logic [1:0]             S_AXI_BRESP;
  logic                   S_AXI_BVALID;
  logic                   S_AXI_BREADY;
  logic [AddrWidth-1:0]   S_AXI_ARADDR;
  logic [2:0]             S_AXI_ARPROT;
  logic                   S_AXI_ARVALID;
  logic                   S_AXI_ARREADY;
  logic [DataWidth-1:0]   S_AXI_RDATA;
  logic [1:0]             S_AXI_RRESP;
  logic                   S_AXI_RVALID;
  logic                   S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/zybo_pwmext_core.sv
// PWM generator: free-running period counter with period/duty shadow registers
// that reload only at a period boundary or when the generator is enabled.
module zybo_pwmext_core (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [31:0] period_i,
  input  logic [31:0] duty_i,
  output logic        pwm_o,
  output logic        period_tick_o
);

  logic        en_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_sh_q, period_sh_d;
  logic [31:0] duty_sh_q, duty_sh_d;
  logic        pwm_q, pwm_d;
  logic        start, run, wrap, load;

  always_comb begin
    start = enable_i & ~en_q;
    run   = enable_i & en_q;
    // PERIOD of 0 or 1 pins the counter at 0 so every cycle is a period start
    wrap  = (period_sh_q <= 32'd1) || (cnt_q >= period_sh_q - 32'd1);
    load  = start | (run & wrap);

    cnt_d       = (run && !wrap) ? cnt_q + 32'd1 : '0;
    period_sh_d = load ? period_i : period_sh_q;
    duty_sh_d   = load ? duty_i : duty_sh_q;
    pwm_d       = run && (cnt_q < duty_sh_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q        <= 1'b0;
      cnt_q       <= '0;
      period_sh_q <= '0;
      duty_sh_q   <= '0;
      pwm_q       <= 1'b0;
    end else begin
      en_q        <= enable_i;
      cnt_q       <= cnt_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_o         = pwm_q;
  assign period_tick_o = run && (cnt_q == '0);

endmodule

// File: rtl/zybo_pwmext_axil_regs.sv
// AXI4-Lite slave with four RW registers (CTRL, PERIOD, DUTY, SCRATCH) driving
// the PWMext core. Read and write channels run independent FSMs.
module zybo_pwmext_axil_regs
  import zybo_pwmext_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  zybo_pwmext_axil_regs_if.slave  axi_io,
  output logic                    pwm_o,
  output logic                    period_tick_o
);

  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [4];
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic      awready_q, awready_d;
  logic      arready_q, arready_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic      wr_fire, rd_fire;
  logic      unused_bits;

  assign awaddr  = axi_io.S_AXI_AWADDR;
  assign araddr  = axi_io.S_AXI_ARADDR;
  assign wr_fire = awready_q & axi_io.S_AXI_AWVALID & axi_io.S_AXI_WVALID;
  assign rd_fire = arready_q & axi_io.S_AXI_ARVALID;
  assign unused_bits = ^{axi_io.S_AXI_AWPROT, axi_io.S_AXI_ARPROT, awaddr[1:0], araddr[1:0]};

  // Write channel: AWREADY/WREADY pulse together only once both valids are up
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = 1'b0;
    regs_d     = regs_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (wr_fire) begin
          wr_state_d = W_RESP;
          regs_d[awaddr[3:2]] = apply_wstrb(regs_q[awaddr[3:2]], axi_io.S_AXI_WDATA,
                                            axi_io.S_AXI_WSTRB);
        end else if (axi_io.S_AXI_AWVALID && axi_io.S_AXI_WVALID) begin
          awready_d = 1'b1;
        end
      end
      W_RESP: if (axi_io.S_AXI_BREADY) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read data is sampled before any same-edge write lands, so it returns the old value
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = 1'b0;
    rdata_d    = rdata_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (rd_fire) begin
          rd_state_d = R_DATA;
          rdata_d    = regs_q[araddr[3:2]];
        end else if (axi_io.S_AXI_ARVALID) begin
          arready_d = 1'b1;
        end
      end
      R_DATA: if (axi_io.S_AXI_RREADY) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      awready_q  <= 1'b0;
      arready_q  <= 1'b0;
      rdata_q    <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= awready_d;
      arready_q  <= arready_d;
      rdata_q    <= rdata_d;
      regs_q     <= regs_d;
    end
  end

  assign axi_io.S_AXI_AWREADY = awready_q;
  assign axi_io.S_AXI_WREADY  = awready_q;
  assign axi_io.S_AXI_BVALID  = (wr_state_q == W_RESP);
  assign axi_io.S_AXI_BRESP   = RESP_OKAY;
  assign axi_io.S_AXI_ARREADY = arready_q;
  assign axi_io.S_AXI_RVALID  = (rd_state_q == R_DATA);
  assign axi_io.S_AXI_RDATA   = rdata_q;
  assign axi_io.S_AXI_RRESP   = RESP_OKAY;

  zybo_pwmext_core u_core (
    .clk_i         (ACLK),
    .rst_ni        (ARESETN),
    .enable_i      (regs_q[REG_CTRL][0]),
    .period_i      (regs_q[REG_PERIOD]),
    .duty_i        (regs_q[REG_DUTY]),
    .pwm_o         (pwm_o),
    .period_tick_o (period_tick_o)
  );

endmodule

// File: tb/tb_zybo_pwmext_axil_regs.sv
// Directed bench for the PWMext AXI4-Lite register block and PWM generator.
module tb_zybo_pwmext_axil_regs;
  import zybo_pwmext_pkg::*;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic pwm, tick;
  int   nvec = 0;
  int   nerr = 0;

  zybo_pwmext_axil_regs_if #(.DataWidth(32), .AddrWidth(4)) bus ();

  zybo_pwmext_axil_regs #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .axi_io        (bus),
    .pwm_o         (pwm),
    .period_tick_o (tick)
  );

  always #5 ACLK = ~ACLK;

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit done;
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_WDATA = data;
    bus.S_AXI_WSTRB = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.S_AXI_AWREADY && bus.S_AXI_WREADY) done = 1;
      cyc();
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID = 1'b0;
    resp = 2'bxx;
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL write_accept_timeout addr=%h got no AWREADY, required within 20 cycles", addr);
      return;
    end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.S_AXI_BVALID) done = 1;
      else cyc();
    end
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL write_resp_timeout addr=%h got no BVALID, required within 20 cycles", addr);
      return;
    end
    resp = bus.S_AXI_BRESP;
    bus.S_AXI_BREADY = 1'b1;
    cyc();
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit done;
    bus.S_AXI_ARADDR = addr;
    bus.S_AXI_ARVALID = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.S_AXI_ARREADY) done = 1;
      cyc();
    end
    bus.S_AXI_ARVALID = 1'b0;
    data = 'x;
    resp = 2'bxx;
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL read_accept_timeout addr=%h got no ARREADY, required within 20 cycles", addr);
      return;
    end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.S_AXI_RVALID) done = 1;
      else cyc();
    end
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL read_data_timeout addr=%h got no RVALID, required within 20 cycles", addr);
      return;
    end
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1'b1;
    cyc();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (tick) seen = 1;
    end
    if (!seen) begin
      nvec++; nerr++;
      $display("FAIL tick_timeout got no period_tick_o, required within 40 cycles");
    end
  endtask

  task automatic capture(output logic [19:0] p, output logic [19:0] t);
    for (int i = 0; i < 20; i++) begin
      cyc();
      p[i] = pwm;
      t[i] = tick;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    repeat (3) cyc();
    nvec++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
         bus.S_AXI_RVALID, bus.S_AXI_RDATA, pwm, tick} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs got aw=%b w=%b ar=%b b=%b r=%b rdata=%h pwm=%b tick=%b, required all 0",
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
               bus.S_AXI_RVALID, bus.S_AXI_RDATA, pwm, tick);
    end
    ARESETN = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r);
      nvec++;
      if (d !== 32'h0) begin
        nerr++;
        $display("FAIL reset_reg%0d got %h, required 00000000", i, d);
      end
    end
  endtask

  task automatic test_rw();
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, r);
      nvec++;
      if (r !== RESP_OKAY) begin
        nerr++;
        $display("FAIL rw_bresp%0d got %b, required 00", i, r);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r);
      nvec++;
      if (d !== 32'(i + 1) || r !== RESP_OKAY) begin
        nerr++;
        $display("FAIL rw_read%0d got %h/%b, required %h/00", i, d, r, 32'(i + 1));
      end
    end
  endtask

  task automatic test_wstrb();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(4'hC, 32'h0, 4'hF, r);
    axi_write(4'hC, 32'hFFFF_FFFF, 4'b0101, r);
    axi_read(4'hC, d, r);
    nvec++;
    if (d !== 32'h00FF_00FF) begin
      nerr++;
      $display("FAIL wstrb_merge got %h, required 00ff00ff", d);
    end
  endtask

  task automatic test_aw_before_w();
    logic [31:0] d;
    logic [1:0]  r;
    bit bad, done;
    bus.S_AXI_AWADDR = 4'hC;
    bus.S_AXI_WDATA = 32'hA5A5_0001;
    bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus.S_AXI_AWREADY || bus.S_AXI_WREADY || bus.S_AXI_BVALID) bad = 1;
    end
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL aw_only_ready got a ready/BVALID while WVALID low, required none");
    end
    bus.S_AXI_WVALID = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.S_AXI_AWREADY) done = 1;
      cyc();
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID = 1'b0;
    nvec++;
    if (!done || bus.S_AXI_BVALID !== 1'b1) begin
      nerr++;
      $display("FAIL aw_w_accept got accepted=%0d bvalid=%b, required 1/1", done, bus.S_AXI_BVALID);
    end
    // Second write presented while BREADY is held low
    bus.S_AXI_WDATA = 32'hA5A5_0002;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_AWREADY !== 1'b0) bad = 1;
    end
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL bresp_hold got BVALID dropped or AWREADY raised, required BVALID=1 AWREADY=0");
    end
    axi_read(4'hC, d, r);
    nvec++;
    if (d !== 32'hA5A5_0001) begin
      nerr++;
      $display("FAIL bresp_hold_data got %h, required a5a50001", d);
    end
    bus.S_AXI_BREADY = 1'b1;
    cyc();
    bus.S_AXI_BREADY = 1'b0;
    nvec++;
    if (bus.S_AXI_BVALID !== 1'b0) begin
      nerr++;
      $display("FAIL single_bvalid got BVALID=%b after handshake, required 0", bus.S_AXI_BVALID);
    end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.S_AXI_AWREADY) done = 1;
      cyc();
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    cyc();
    bus.S_AXI_BREADY = 1'b0;
    axi_read(4'hC, d, r);
    nvec++;
    if (!done || d !== 32'hA5A5_0002) begin
      nerr++;
      $display("FAIL second_write got accepted=%0d data=%h, required 1/a5a50002", done, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0]  r, rw;
    axi_write(4'hC, 32'h1111_1111, 4'hF, r);
    fork
      axi_write(4'hC, 32'h2222_2222, 4'hF, rw);
      axi_read(4'hC, d, r);
    join
    nvec++;
    if (d !== 32'h1111_1111) begin
      nerr++;
      $display("FAIL same_cycle_rw got %h, required 11111111", d);
    end
    axi_read(4'hC, d, r);
    nvec++;
    if (d !== 32'h2222_2222) begin
      nerr++;
      $display("FAIL after_rw got %h, required 22222222", d);
    end
  endtask

  task automatic test_pwm();
    logic [1:0]  r;
    logic [19:0] p, t;
    axi_write(4'h0, 32'h0, 4'hF, r);
    cyc();
    nvec++;
    if (pwm !== 1'b0 || tick !== 1'b0) begin
      nerr++;
      $display("FAIL disabled got pwm=%b tick=%b, required 0/0", pwm, tick);
    end
    axi_write(4'h4, 32'd10, 4'hF, r);
    axi_write(4'h8, 32'd3, 4'hF, r);
    axi_write(4'h0, 32'h1, 4'hF, r);
    wait_tick();
    capture(p, t);
    nvec++;
    if (p !== 20'h01C07 || t !== 20'h80200) begin
      nerr++;
      $display("FAIL pwm_10_3 got pwm=%h tick=%h, required 01c07/80200", p, t);
    end
  endtask

  task automatic test_duty_change();
    logic [1:0]  r;
    logic [19:0] p, t;
    wait_tick();
    fork
      axi_write(4'h8, 32'd7, 4'hF, r);
      capture(p, t);
    join
    nvec++;
    if (p !== 20'h1FC07 || t !== 20'h80200) begin
      nerr++;
      $display("FAIL duty_midperiod got pwm=%h tick=%h, required 1fc07/80200", p, t);
    end
  endtask

  task automatic test_boundaries();
    logic [1:0]  r;
    logic [19:0] p, t;
    axi_write(4'h8, 32'd12, 4'hF, r);
    wait_tick();
    capture(p, t);
    nvec++;
    if (p !== 20'hFFFFF || t !== 20'h80200) begin
      nerr++;
      $display("FAIL duty_ge_period got pwm=%h tick=%h, required fffff/80200", p, t);
    end
    axi_write(4'h8, 32'd0, 4'hF, r);
    wait_tick();
    capture(p, t);
    nvec++;
    if (p !== 20'h00000 || t !== 20'h80200) begin
      nerr++;
      $display("FAIL duty_zero got pwm=%h tick=%h, required 00000/80200", p, t);
    end
    axi_write(4'h4, 32'd1, 4'hF, r);
    axi_write(4'h8, 32'd5, 4'hF, r);
    wait_tick();
    capture(p, t);
    nvec++;
    if (p !== 20'hFFFFF || t !== 20'hFFFFF) begin
      nerr++;
      $display("FAIL period_one got pwm=%h tick=%h, required fffff/fffff", p, t);
    end
    axi_write(4'h0, 32'h0, 4'hF, r);
    nvec++;
    if (pwm !== 1'b0 || tick !== 1'b0) begin
      nerr++;
      $display("FAIL ctrl_clear got pwm=%b tick=%b, required 0/0", pwm, tick);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    bit bad, done;
    axi_write(4'h4, 32'd10, 4'hF, r);
    axi_write(4'h8, 32'd12, 4'hF, r);
    axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, r);
    axi_write(4'h0, 32'h1, 4'hF, r);
    wait_tick();
    cyc();
    bus.S_AXI_ARADDR = 4'hC;
    bus.S_AXI_ARVALID = 1'b1;
    cyc();
    nvec++;
    if (bus.S_AXI_RVALID !== 1'b0 || pwm !== 1'b1) begin
      nerr++;
      $display("FAIL read_latency got rvalid=%b pwm=%b one cycle after ARVALID, required 0/1",
               bus.S_AXI_RVALID, pwm);
    end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.S_AXI_ARREADY) done = 1;
      cyc();
    end
    bus.S_AXI_ARVALID = 1'b0;
    bad = !done;
    for (int i = 0; i < 3; i++) begin
      if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'hDEAD_BEEF) bad = 1;
      cyc();
    end
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL rdata_hold got rvalid=%b rdata=%h, required 1/deadbeef held",
               bus.S_AXI_RVALID, bus.S_AXI_RDATA);
    end
    ARESETN = 1'b0;
    #1;
    nvec++;
    if (bus.S_AXI_RVALID !== 1'b0 || pwm !== 1'b0 || tick !== 1'b0 || bus.S_AXI_RDATA !== 32'h0) begin
      nerr++;
      $display("FAIL async_reset got rvalid=%b pwm=%b tick=%b rdata=%h, required 0/0/0/0",
               bus.S_AXI_RVALID, pwm, tick, bus.S_AXI_RDATA);
    end
    cyc();
    cyc();
    ARESETN = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r);
      nvec++;
      if (d !== 32'h0 || pwm !== 1'b0) begin
        nerr++;
        $display("FAIL post_reset_reg%0d got %h pwm=%b, required 00000000/0", i, d, pwm);
      end
    end
  endtask

  initial begin
    bus.S_AXI_AWADDR = '0;
    bus.S_AXI_AWPROT = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;
    bus.S_AXI_WSTRB = '0;
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0;
    bus.S_AXI_ARPROT = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    test_reset();
    test_rw();
    test_wstrb();
    test_aw_before_w();
    test_back_to_back();
    test_pwm();
    test_duty_change();
    test_boundaries();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish within 1 ms");
    $fatal(1);
  end

endmodule
